// File: rtl/audio_stats_pkg.sv
// Shared defaults and full-scale helpers for the audio statistics monitor.
package audio_stats_pkg;

    localparam int unsigned DefWidth   = 16;
    localparam int unsigned DefNumCh   = 2;
    localparam int unsigned DefWinLog2 = 10;

    function automatic int fs_max(input int unsigned width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int fs_min(input int unsigned width);
        return -(1 << (width - 1));
    endfunction

endpackage

// File: rtl/audio_stats_chan.sv
// One channel's window accumulators, sign history and latched window results.
module audio_stats_chan
    import audio_stats_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned WIN_LOG2 = DefWinLog2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vld,
    input  logic                clr,
    input  logic                wrap,
    input  logic [WIDTH-1:0]    sample,
    output logic [WIDTH-1:0]    max_res,
    output logic [WIDTH-1:0]    min_res,
    output logic [WIDTH-1:0]    mean_res,
    output logic [WIN_LOG2:0]   xing_res,
    output logic [WIN_LOG2:0]   clip_res
);

    localparam int unsigned SumW = WIDTH + WIN_LOG2;
    localparam logic signed [WIDTH-1:0] FsMax  = WIDTH'(fs_max(WIDTH));
    localparam logic signed [WIDTH-1:0] FsMin  = WIDTH'(fs_min(WIDTH));
    localparam logic [WIN_LOG2:0]       CntOne = (WIN_LOG2 + 1)'(1);

    logic signed [WIDTH-1:0] smp;
    logic signed [WIDTH-1:0] max_q, max_d, min_q, min_d, mean_d;
    logic signed [SumW-1:0]  sum_q, sum_d;
    logic [WIN_LOG2:0]       xing_q, xing_d, clip_q, clip_d;
    logic                    hist_vld_q, prev_neg_q, neg;

    assign smp = sample;
    assign neg = smp[WIDTH-1];

    always_comb begin
        max_d  = (smp > max_q) ? smp : max_q;
        min_d  = (smp < min_q) ? smp : min_q;
        sum_d  = sum_q + SumW'(smp);
        // Arithmetic shift gives floor toward -inf for negative sums.
        mean_d = WIDTH'(sum_d >>> WIN_LOG2);
        xing_d = xing_q;
        if (hist_vld_q && (neg != prev_neg_q)) begin
            xing_d = xing_q + CntOne;
        end
        clip_d = clip_q;
        if ((smp == FsMax) || (smp == FsMin)) begin
            clip_d = clip_q + CntOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q      <= FsMin;
            min_q      <= FsMax;
            sum_q      <= '0;
            xing_q     <= '0;
            clip_q     <= '0;
            hist_vld_q <= 1'b0;
            prev_neg_q <= 1'b0;
            max_res    <= '0;
            min_res    <= '0;
            mean_res   <= '0;
            xing_res   <= '0;
            clip_res   <= '0;
        end else if (clr) begin
            max_q      <= FsMin;
            min_q      <= FsMax;
            sum_q      <= '0;
            xing_q     <= '0;
            clip_q     <= '0;
            hist_vld_q <= 1'b0;
            prev_neg_q <= 1'b0;
        end else if (vld) begin
            // History survives the window boundary so cross-window sign changes count.
            hist_vld_q <= 1'b1;
            prev_neg_q <= neg;
            if (wrap) begin
                max_res  <= max_d;
                min_res  <= min_d;
                mean_res <= mean_d;
                xing_res <= xing_d;
                clip_res <= clip_d;
                max_q    <= FsMin;
                min_q    <= FsMax;
                sum_q    <= '0;
                xing_q   <= '0;
                clip_q   <= '0;
            end else begin
                max_q  <= max_d;
                min_q  <= min_d;
                sum_q  <= sum_d;
                xing_q <= xing_d;
                clip_q <= clip_d;
            end
        end
    end

endmodule

// File: rtl/audio_stats_mon.sv
// Per-channel windowed audio statistics with a pend/ack result handshake.
module audio_stats_mon
    import audio_stats_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned NUM_CH   = DefNumCh,
    parameter int unsigned WIN_LOG2 = DefWinLog2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         smpl_vld,
    input  logic [NUM_CH*WIDTH-1:0]      smpl,
    input  logic                         clr,
    input  logic                         stats_ack,
    output logic                         stats_vld,
    output logic                         stats_pend,
    output logic                         overrun,
    output logic [NUM_CH*WIDTH-1:0]      max_o,
    output logic [NUM_CH*WIDTH-1:0]      min_o,
    output logic [NUM_CH*WIDTH-1:0]      mean_o,
    output logic [NUM_CH*(WIN_LOG2+1)-1:0] xing_o,
    output logic [NUM_CH*(WIN_LOG2+1)-1:0] clip_o
);

    logic [WIN_LOG2-1:0] cnt_q;
    logic                wrap, done;

    // The frame arriving at count 2^WIN_LOG2-1 closes the window.
    assign wrap = &cnt_q;
    assign done = smpl_vld && !clr && wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            stats_vld  <= 1'b0;
            stats_pend <= 1'b0;
            overrun    <= 1'b0;
        end else if (clr) begin
            cnt_q      <= '0;
            stats_vld  <= 1'b0;
            stats_pend <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (smpl_vld) begin
                cnt_q <= cnt_q + WIN_LOG2'(1);
            end
            stats_vld <= done;
            if (done) begin
                stats_pend <= 1'b1;
                if (stats_pend && !stats_ack) begin
                    overrun <= 1'b1;
                end
            end else if (stats_ack) begin
                stats_pend <= 1'b0;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        audio_stats_chan #(
            .WIDTH    (WIDTH),
            .WIN_LOG2 (WIN_LOG2)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .vld      (smpl_vld),
            .clr      (clr),
            .wrap     (wrap),
            .sample   (smpl[c*WIDTH +: WIDTH]),
            .max_res  (max_o[c*WIDTH +: WIDTH]),
            .min_res  (min_o[c*WIDTH +: WIDTH]),
            .mean_res (mean_o[c*WIDTH +: WIDTH]),
            .xing_res (xing_o[c*(WIN_LOG2+1) +: (WIN_LOG2+1)]),
            .clip_res (clip_o[c*(WIN_LOG2+1) +: (WIN_LOG2+1)])
        );
    end

endmodule

// File: tb/tb_audio_stats_mon.sv
// Bench for audio_stats_mon: directed scenarios plus random traffic vs. a window-list model.
module tb_audio_stats_mon;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned NUM_CH   = 2;
    localparam int unsigned WIN_LOG2 = 3;
    localparam int          WIN      = 1 << WIN_LOG2;
    localparam int          VW       = 3 + 3 * NUM_CH * WIDTH + 2 * NUM_CH * (WIN_LOG2 + 1);

    logic                            clk, rst_n, smpl_vld, clr, stats_ack;
    logic [NUM_CH*WIDTH-1:0]         smpl;
    logic                            stats_vld, stats_pend, overrun;
    logic [NUM_CH*WIDTH-1:0]         max_o, min_o, mean_o;
    logic [NUM_CH*(WIN_LOG2+1)-1:0]  xing_o, clip_o;

    int n_checks = 0;
    int n_pass   = 0;

    audio_stats_mon #(
        .WIDTH    (WIDTH),
        .NUM_CH   (NUM_CH),
        .WIN_LOG2 (WIN_LOG2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .smpl_vld   (smpl_vld),
        .smpl       (smpl),
        .clr        (clr),
        .stats_ack  (stats_ack),
        .stats_vld  (stats_vld),
        .stats_pend (stats_pend),
        .overrun    (overrun),
        .max_o      (max_o),
        .min_o      (min_o),
        .mean_o     (mean_o),
        .xing_o     (xing_o),
        .clip_o     (clip_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: the window is a list of frames; statistics are computed when it fills.
    logic [31:0] m_frames[$];
    int m_max[NUM_CH], m_min[NUM_CH], m_mean[NUM_CH], m_xing[NUM_CH], m_clip[NUM_CH];
    int m_xing_acc[NUM_CH];
    bit m_pn[NUM_CH];
    bit m_hv, m_vld, m_pend, m_ovr;

    task automatic model_reset();
        m_frames.delete();
        for (int c = 0; c < NUM_CH; c++) begin
            m_max[c] = 0; m_min[c] = 0; m_mean[c] = 0; m_xing[c] = 0; m_clip[c] = 0;
            m_xing_acc[c] = 0; m_pn[c] = 0;
        end
        m_hv = 0; m_vld = 0; m_pend = 0; m_ovr = 0;
    endtask

    task automatic model_step(input bit vld, input logic [15:0] s0, input logic [15:0] s1,
                              input bit do_clr, input bit ack);
        bit done = 0;
        m_vld = 0;
        if (do_clr) begin
            m_frames.delete();
            m_hv = 0;
            for (int c = 0; c < NUM_CH; c++) m_xing_acc[c] = 0;
            m_pend = 0;
            m_ovr  = 0;
            return;
        end
        if (vld) begin
            for (int c = 0; c < NUM_CH; c++) begin
                logic signed [15:0] ss = (c == 0) ? s0 : s1;
                bit neg = (ss < 0);
                if (m_hv && neg != m_pn[c]) m_xing_acc[c]++;
                m_pn[c] = neg;
            end
            m_hv = 1;
            m_frames.push_back({s1, s0});
            if (m_frames.size() == WIN) begin
                done = 1;
                for (int c = 0; c < NUM_CH; c++) begin
                    int mx = -32768, mn = 32767, sum = 0, cl = 0;
                    foreach (m_frames[i]) begin
                        logic signed [15:0] ss = m_frames[i][c*16 +: 16];
                        int v = ss;
                        if (v > mx) mx = v;
                        if (v < mn) mn = v;
                        sum += v;
                        if (v == 32767 || v == -32768) cl++;
                    end
                    m_max[c]  = mx;
                    m_min[c]  = mn;
                    m_mean[c] = (sum >= 0) ? sum / WIN : -((-sum + WIN - 1) / WIN);
                    m_clip[c] = cl;
                    m_xing[c] = m_xing_acc[c];
                    m_xing_acc[c] = 0;
                end
                m_frames.delete();
            end
        end
        if (done) begin
            if (m_pend && !ack) m_ovr = 1;
            m_pend = 1;
            m_vld  = 1;
        end else if (ack) begin
            m_pend = 0;
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [NUM_CH*WIDTH-1:0] mx, mn, mean;
        logic [NUM_CH*(WIN_LOG2+1)-1:0] xg, cl;
        for (int c = 0; c < NUM_CH; c++) begin
            mx[c*WIDTH +: WIDTH]   = m_max[c][WIDTH-1:0];
            mn[c*WIDTH +: WIDTH]   = m_min[c][WIDTH-1:0];
            mean[c*WIDTH +: WIDTH] = m_mean[c][WIDTH-1:0];
            xg[c*(WIN_LOG2+1) +: (WIN_LOG2+1)] = m_xing[c][WIN_LOG2:0];
            cl[c*(WIN_LOG2+1) +: (WIN_LOG2+1)] = m_clip[c][WIN_LOG2:0];
        end
        return {m_vld, m_pend, m_ovr, mx, mn, mean, xg, cl};
    endfunction

    function automatic logic [VW-1:0] act_vec();
        return {stats_vld, stats_pend, overrun, max_o, min_o, mean_o, xing_o, clip_o};
    endfunction

    task automatic step(input bit vld, input logic [15:0] s0, input logic [15:0] s1,
                        input bit do_clr, input bit ack);
        @(negedge clk);
        smpl_vld  = vld;
        smpl      = {s1, s0};
        clr       = do_clr;
        stats_ack = ack;
        @(posedge clk);
        model_step(vld, s0, s1, do_clr, ack);
        #1;
        smpl_vld  = 1'b0;
        clr       = 1'b0;
        stats_ack = 1'b0;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h7fff;
            1:       return 16'h8000;
            2:       return 16'h0000;
            3:       return 16'hffff;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; smpl_vld = 1'b0; smpl = '0; clr = 1'b0; stats_ack = 1'b0;
        model_reset();
        #3;
        if (act_vec() !== exp_vec())
            $display("FAIL reset: got %h expected %h", act_vec(), exp_vec());
        else n_pass++;
        n_checks++;
        #9 rst_n = 1'b1;
    endtask

    task automatic test_window_a();
        logic [15:0] a0 [8] = '{16'd100, -16'sd200, 16'd300, -16'sd400,
                                16'd500, -16'sd600, 16'd700, -16'sd800};
        for (int i = 0; i < WIN; i++) begin
            step(1, a0[i], 16'h7fff, 0, 0);
            if (act_vec() !== exp_vec())
                $display("FAIL window_a[%0d]: got %h expected %h", i, act_vec(), exp_vec());
            else n_pass++;
            n_checks++;
        end
        if ($signed(mean_o[15:0]) !== -16'sd50 || $signed(min_o[15:0]) !== -16'sd800 ||
            xing_o[3:0] !== 4'd7 || clip_o[7:4] !== 4'd8)
            $display("FAIL window_a_const: got mean %0d min %0d xing %0d clip1 %0d expected -50 -800 7 8",
                     $signed(mean_o[15:0]), $signed(min_o[15:0]), xing_o[3:0], clip_o[7:4]);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_overrun();
        for (int i = 0; i < WIN; i++) begin
            step(1, 16'd5, 16'h7fff, 0, 0);
            if (act_vec() !== exp_vec())
                $display("FAIL overrun[%0d]: got %h expected %h", i, act_vec(), exp_vec());
            else n_pass++;
            n_checks++;
        end
        if (xing_o[3:0] !== 4'd1 || overrun !== 1'b1 || stats_pend !== 1'b1)
            $display("FAIL overrun_const: got xing %0d ovr %b pend %b expected 1 1 1",
                     xing_o[3:0], overrun, stats_pend);
        else n_pass++;
        n_checks++;
        step(0, 0, 0, 0, 0);
        if (act_vec() !== exp_vec())
            $display("FAIL overrun_idle: got %h expected %h", act_vec(), exp_vec());
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_floor_ack();
        step(0, 0, 0, 1, 0);
        if (act_vec() !== exp_vec())
            $display("FAIL clr_hold: got %h expected %h", act_vec(), exp_vec());
        else n_pass++;
        n_checks++;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < WIN; i++) begin
                logic [15:0] s0 = (w == 0) ? ((i == WIN - 1) ? 16'hffff : 16'h0) : pick();
                step(1, s0, pick(), 0, i == WIN - 1);
                if (act_vec() !== exp_vec())
                    $display("FAIL floor_ack w%0d[%0d]: got %h expected %h",
                             w, i, act_vec(), exp_vec());
                else n_pass++;
                n_checks++;
            end
            if (w == 0) begin
                if (mean_o[15:0] !== 16'hffff || xing_o[3:0] !== 4'd1)
                    $display("FAIL floor_const: got mean %h xing %0d expected ffff 1",
                             mean_o[15:0], xing_o[3:0]);
                else n_pass++;
                n_checks++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0, 1);
            if (act_vec() !== exp_vec())
                $display("FAIL ack_only[%0d]: got %h expected %h", i, act_vec(), exp_vec());
            else n_pass++;
            n_checks++;
        end
    endtask

    task automatic test_clr_mid();
        for (int i = 0; i < 5 + 1 + WIN; i++) begin
            step(1, pick(), pick(), i == 5, 0);
            if (act_vec() !== exp_vec())
                $display("FAIL clr_mid[%0d]: got %h expected %h", i, act_vec(), exp_vec());
            else n_pass++;
            n_checks++;
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step(1, pick(), pick(), 0, 0);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        if (act_vec() !== exp_vec())
            $display("FAIL async_reset: got %h expected %h", act_vec(), exp_vec());
        else n_pass++;
        n_checks++;
        #2 rst_n = 1'b1;
        for (int i = 0; i < WIN + 1; i++) begin
            step(i < WIN, pick(), pick(), 0, 0);
            if (act_vec() !== exp_vec())
                $display("FAIL post_reset[%0d]: got %h expected %h", i, act_vec(), exp_vec());
            else n_pass++;
            n_checks++;
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int idx[$];
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 3 * WIN; i++) begin
            step(1, pick(), pick(), 0, $urandom_range(0, 1));
            if (stats_vld) begin
                pulses++;
                idx.push_back(i);
            end
            if (act_vec() !== exp_vec())
                $display("FAIL b2b[%0d]: got %h expected %h", i, act_vec(), exp_vec());
            else n_pass++;
            n_checks++;
        end
        if (pulses !== 3)
            $display("FAIL b2b_pulses: got %0d expected 3", pulses);
        else n_pass++;
        n_checks++;
        for (int k = 0; k < idx.size(); k++) begin
            if (idx[k] !== WIN * k + WIN - 1)
                $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", k, idx[k], WIN * k + WIN - 1);
            else n_pass++;
            n_checks++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 3) != 0, pick(), pick(), $urandom_range(0, 40) == 0,
                 $urandom_range(0, 4) == 0);
            if (act_vec() !== exp_vec())
                $display("FAIL random[%0d]: got %h expected %h", i, act_vec(), exp_vec());
            else n_pass++;
            n_checks++;
        end
    endtask

    initial begin
        test_reset();
        test_window_a();
        test_overrun();
        test_floor_ack();
        test_clr_mid();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/audio_stats_mon.md
Name: audio_stats_mon

Overview:
- Synthesizable, parametrised per-channel audio statistics monitor sitting on the equalizer's output sample stream, in parallel with the CODEC serializer.
- Over a fixed window of 2^WIN_LOG2 valid sample frames, each channel accumulates max, min, mean (floor), sign-change crossings and full-scale clip count.
- At window end the results are latched, and a pend/ack handshake with sticky overrun lets firmware or a bench read them.

Parameters:
WIDTH, 16, signed sample width per channel
NUM_CH, 2, number of channels (ch0 = LSBs of packed vectors)
WIN_LOG2, 10, log2 of window length in sample frames (legal 1..16)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
smpl_vld  in  1  one-cycle strobe: smpl holds one frame (all channels)
smpl  in  NUM_CH*WIDTH  signed samples, channel c at [c*WIDTH +: WIDTH]
clr  in  1  synchronous clear of window state and previous-sign history
stats_ack  in  1  consumer acknowledges latched results
stats_vld  out  1  one-cycle pulse: new results latched
stats_pend  out  1  results latched and not yet acknowledged
overrun  out  1  sticky: window completed while stats_pend was 1; cleared only by clr or reset
max_o  out  NUM_CH*WIDTH  per-channel window maximum (signed)
min_o  out  NUM_CH*WIDTH  per-channel window minimum (signed)
mean_o  out  NUM_CH*WIDTH  per-channel floor(sum / 2^WIN_LOG2) (signed)
xing_o  out  NUM_CH*(WIN_LOG2+1)  per-channel sign-change count
clip_o  out  NUM_CH*(WIN_LOG2+1)  per-channel count of samples equal to +FS or -FS

Behaviour:
- Reset (async, rst_n=0): all outputs 0; window counter 0; running max = -2^(WIDTH-1); running min = 2^(WIDTH-1)-1; sums/counts 0; prev-sign history invalid.
- Accumulation on smpl_vld=1 and clr=0, per channel: max/min signed compare; sum += sign-extended sample, accumulator width WIDTH+WIN_LOG2, no overflow possible; clip++ if sample == 2^(WIDTH-1)-1 or == -2^(WIDTH-1).
- Sign: sample < 0 is negative; zero counts as non-negative.
- Crossing: xing++ when history is valid and the sign differs from the previous sample's sign. History persists across window boundaries and is invalidated only by clr or reset.
- Window: a counter increments per accepted frame. The frame making the count 2^WIN_LOG2 is included in the window. In the same clock edge: results register, counter wraps to 0, accumulators reinitialise to their reset values.
- Latency: stats_vld and the updated result outputs appear on the cycle after the final frame's smpl_vld. Results hold until the next window completes.
- mean = arithmetic shift right of sum by WIN_LOG2, i.e. floor toward -inf; -1/8 yields -1.
- Handshake:
  - stats_pend sets on window completion; clears on stats_ack.
  - Completion and stats_ack in the same cycle: pend stays 1 and overrun is not set.
  - Completion while pend=1 and no ack: overrun sets and results are overwritten.
  - stats_ack with pend=0 is ignored.
- clr:
  - Resets window counter, accumulators, history, stats_pend and overrun.
  - Latched result outputs keep their values.
  - clr and smpl_vld in the same cycle: clr wins and the sample is discarded.
- smpl_vld may be asserted on consecutive cycles; full throughput, one frame per clock.

Decomposition:
- Package audio_stats_pkg: default WIDTH/NUM_CH/WIN_LOG2 constants; a function computing the +FS/-FS limits from width.
- Sub-module audio_stats_chan: one channel's max/min/sum/xing/clip/history registers. Inputs: vld, clr, wrap, sample. Outputs: registered results.
- Top level: generate-loop over NUM_CH instances of audio_stats_chan, plus the shared window counter and the pend/overrun handshake logic.

Test Plan:
- Setup: WIN_LOG2=3, NUM_CH=2, after reset.
- Window A: ch0 = 100,-200,300,-400,500,-600,700,-800; ch1 = 32767 x8 -> stats_vld 1 cycle after 8th vld. ch0: max 700, min -800, mean -50, xing 7, clip 0. ch1: max=min=mean 32767, xing 0, clip 8.
- Window B, immediately after A: ch0 = 5 x8 -> xing 1 (cross-window, -800 to 5), mean 5, max=min 5. No ack given before completion -> overrun=1, pend=1.
- After clr: ch0 = 0 x7 then -1 -> mean -1 (floor), xing 1, min -1, max 0. ack coincident with completion -> pend stays 1, overrun stays 0.
- clr asserted together with the 6th vld of a window -> no stats_vld until 8 further frames; results exclude all pre-clr samples; latched outputs unchanged until then.
- rst_n low for 3 ns mid-window with no clk edge -> all outputs 0 immediately; next full window reports correctly from scratch.
- Back-to-back smpl_vld on every cycle for 3 windows -> exactly 3 stats_vld pulses, 8 cycles apart.
